// File: rtl/division_bram_if.sv
// Bus bundle for division_bram: BRAM access, start strobe and result handshake.
// Check ports exist only when DIV_CHECK_EN is defined.
interface division_bram_if #(
    parameter int DW = 8,
    parameter int AW = 8
);
    logic            r_w;
    logic            str;
    logic [AW-1:0]   address;
    logic [DW-1:0]   div_const;
    logic [2*DW-1:0] dividend;
    logic            busy;
    logic            done;
    logic [2*DW-1:0] quot;
    logic [DW-1:0]   rem;
    logic            div_zero;
`ifdef DIV_CHECK_EN
    logic [2*DW-1:0] quot_exp;
    logic [DW-1:0]   rem_exp;
    logic            chk_err;
`endif

    modport master (
        output r_w, str, address, div_const, dividend,
`ifdef DIV_CHECK_EN
        input  quot_exp, rem_exp, chk_err,
`endif
        input  busy, done, quot, rem, div_zero
    );

    modport slave (
        input  r_w, str, address, div_const, dividend,
`ifdef DIV_CHECK_EN
        output quot_exp, rem_exp, chk_err,
`endif
        output busy, done, quot, rem, div_zero
    );
endinterface

// File: rtl/division_bram.sv
// Restoring divider by a BRAM-stored constant: 2*DW-bit dividend, DW-bit divisor.
// Define DIV_CHECK_EN to add behavioural reference outputs and a mismatch flag.
module division_bram #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    division_bram_if.slave bus
);
    localparam int CW = $clog2(2*DW);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state, state_nx;
    logic [DW-1:0]   mem [2**AW];
    logic [DW-1:0]   reg_b, dsr_q;
    logic [2*DW-1:0] dvd_q, q_nx, quot_q;
    logic [DW:0]     pr_q, pr_sh, pr_nx;
    logic [CW-1:0]   cnt_q;
    logic [DW-1:0]   rem_q;
    logic            zero_q, ge, last, b_zero;

    always_ff @(posedge clk) begin
        if (!bus.r_w) mem[bus.address] <= bus.div_const;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          reg_b <= '0;
        else if (bus.r_w)  reg_b <= mem[bus.address];
    end

    // Dividend register doubles as quotient shift register.
    always_comb begin
        b_zero = (reg_b == '0);
        last   = (cnt_q == CW'(2*DW-1));
        pr_sh  = {pr_q[DW-1:0], dvd_q[2*DW-1]};
        ge     = (pr_sh >= {1'b0, dsr_q});
        pr_nx  = ge ? pr_sh - {1'b0, dsr_q} : pr_sh;
        q_nx   = {dvd_q[2*DW-2:0], ge};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (bus.str) state_nx = b_zero ? DONE : CALC;
            CALC: if (last)    state_nx = DONE;
            DONE:              state_nx = IDLE;
            default:           state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dvd_q  <= '0;
            dsr_q  <= '0;
            pr_q   <= '0;
            cnt_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            zero_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.str && b_zero) begin
                        quot_q <= '1;
                        rem_q  <= bus.dividend[DW-1:0];
                        zero_q <= 1'b1;
                    end else if (bus.str) begin
                        dvd_q <= bus.dividend;
                        dsr_q <= reg_b;
                        pr_q  <= '0;
                        cnt_q <= '0;
                    end
                end
                CALC: begin
                    dvd_q <= q_nx;
                    pr_q  <= pr_nx;
                    cnt_q <= cnt_q + 1'b1;
                    if (last) begin
                        quot_q <= q_nx;
                        rem_q  <= pr_nx[DW-1:0];
                        zero_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (state == CALC);
    assign bus.done     = (state == DONE);
    assign bus.quot     = quot_q;
    assign bus.rem      = rem_q;
    assign bus.div_zero = zero_q;

`ifdef DIV_CHECK_EN
    logic [2*DW-1:0] dvd_o, qe_q;
    logic [DW-1:0]   re_q;
    logic [2*DW-1:0] dsr_w;

    assign dsr_w = {{DW{1'b0}}, dsr_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dvd_o <= '0;
            qe_q  <= '0;
            re_q  <= '0;
        end else begin
            if (state == IDLE && bus.str && b_zero) begin
                qe_q <= '1;
                re_q <= bus.dividend[DW-1:0];
            end else if (state == IDLE && bus.str) begin
                dvd_o <= bus.dividend;
            end else if (state == CALC && last) begin
                qe_q <= dvd_o / dsr_w;
                re_q <= DW'(dvd_o % dsr_w);
            end
        end
    end

    assign bus.quot_exp = qe_q;
    assign bus.rem_exp  = re_q;
    assign bus.chk_err  = bus.done && (quot_q != qe_q || rem_q != re_q);
`endif
endmodule
